virtual_src: RTL

- Virtual traffic injector that drives one network injection port (cast or gather in) with synthetic packets.
- It is the transmit end of the valid/ready flit stream that virtual PEs consume.
- No real computation. It produces correctly framed head/body/tail flits at a fixed count, so network-wide deadlock and throughput tests can start traffic from the edge nodes.

---
 rtl/vsrc_pkg.sv | 36 +++
 rtl/vsrc_flit_fmt.sv | 21 ++
 rtl/virtual_src.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vsrc_pkg.sv
// Shared flit format and FSM definitions for the virtual traffic source.
// `DW (flit width) and `PKT_LEN (default packet length) fall back to defaults here.
`ifndef DW
`define DW 32
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

package vsrc_pkg;

  localparam int FLIT_W = `DW;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10
  } flit_type_t;

  localparam int TYPE_LSB  = FLIT_W - 2;
  localparam int LOC_Y_LSB = 0;
  localparam int LOC_X_LSB = 4;
  localparam int IDX_LSB   = 8;
  localparam int COORD_W   = 4;
  localparam int IDX_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    BODY,
    TAIL,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/vsrc_flit_fmt.sv
// Combinational flit builder: packs type, coordinate pair and index into one flit word.
// Heads carry the destination in the coordinate fields, body/tail flits carry the source.
module vsrc_flit_fmt
  import vsrc_pkg::*;
(
  input  flit_type_t         type_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [FLIT_W-1:0]  flit_o
);

  always_comb begin
    flit_o = '0;
    flit_o[TYPE_LSB +: 2]        = type_i;
    flit_o[IDX_LSB +: IDX_W]     = idx_i;
    flit_o[LOC_X_LSB +: COORD_W] = x_i;
    flit_o[LOC_Y_LSB +: COORD_W] = y_i;
  end

endmodule

// File: rtl/virtual_src.sv
// Virtual traffic injector: streams num_pkt framed packets of pkt_len flits after start_i.
// Optional macro VSRC_GAP_EN inserts `gap` idle cycles between packets.
module virtual_src
  import vsrc_pkg::*;
#(
  parameter int x       = 0,
  parameter int y       = 0,
  parameter int dst_x   = 0,
  parameter int dst_y   = 0,
  parameter int num_pkt = 10000,
  parameter int pkt_len = `PKT_LEN,
  parameter int gap     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [`DW-1:0]    data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       pkt_cnt_o
);

  if (pkt_len < 3 || num_pkt < 1 || num_pkt > 65535 || gap < 0) begin : g_cfg_err
    $error("virtual_src: unsupported parameter set");
  end

  localparam logic [15:0]        LAST_BODY = 16'(pkt_len - 2);
  localparam logic [15:0]        LAST_PKT  = 16'(num_pkt - 1);
  localparam logic [COORD_W-1:0] SRC_X     = COORD_W'(x);
  localparam logic [COORD_W-1:0] SRC_Y     = COORD_W'(y);
  localparam logic [COORD_W-1:0] DST_X     = COORD_W'(dst_x);
  localparam logic [COORD_W-1:0] DST_Y     = COORD_W'(dst_y);
`ifdef VSRC_GAP_EN
  localparam logic [15:0]        GAP_CYC   = 16'(gap);
`endif

  state_t            state_q, state_d;
  logic [15:0]       flit_cnt_q, flit_cnt_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              valid_q, valid_d;
  logic [FLIT_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef VSRC_GAP_EN
  logic [15:0]       gap_cnt_q, gap_cnt_d;
`endif

  flit_type_t         fmt_type;
  logic [COORD_W-1:0] fmt_x, fmt_y;
  logic [IDX_W-1:0]   fmt_idx;
  logic [FLIT_W-1:0]  fmt_flit;
  logic               xfer;

  assign xfer = valid_q & ready_i;

  // The formatter always builds the flit that would be presented next,
  // so it depends on registered state only and never on ready_i.
  always_comb begin
    fmt_type = FLIT_HEAD;
    fmt_idx  = pkt_cnt_q;
    fmt_x    = DST_X;
    fmt_y    = DST_Y;
    case (state_q)
      HEAD, BODY: begin
        fmt_type = (state_q == BODY && flit_cnt_q == LAST_BODY) ? FLIT_TAIL : FLIT_BODY;
        fmt_idx  = flit_cnt_q + 16'd1;
        fmt_x    = SRC_X;
        fmt_y    = SRC_Y;
      end
      TAIL:    fmt_idx = pkt_cnt_q + 16'd1;
      default: ;
    endcase
  end

  vsrc_flit_fmt u_fmt (
    .type_i (fmt_type),
    .x_i    (fmt_x),
    .y_i    (fmt_y),
    .idx_i  (fmt_idx),
    .flit_o (fmt_flit)
  );

  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    valid_d    = valid_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef VSRC_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = HEAD;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          data_d  = fmt_flit;
        end
      end
      HEAD: begin
        if (xfer) begin
          state_d    = BODY;
          flit_cnt_d = 16'd1;
          data_d     = fmt_flit;
        end
      end
      BODY: begin
        if (xfer) begin
          flit_cnt_d = flit_cnt_q + 16'd1;
          data_d     = fmt_flit;
          if (flit_cnt_q == LAST_BODY) state_d = TAIL;
        end
      end
      TAIL: begin
        if (xfer) begin
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
          flit_cnt_d = 16'd0;
          if (pkt_cnt_q == LAST_PKT) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            data_d  = '0;
          end else begin
`ifdef VSRC_GAP_EN
            if (GAP_CYC != 16'd0) begin
              state_d   = GAP;
              valid_d   = 1'b0;
              data_d    = '0;
              gap_cnt_d = GAP_CYC - 16'd1;
            end else begin
              state_d = HEAD;
              data_d  = fmt_flit;
            end
`else
            state_d = HEAD;
            data_d  = fmt_flit;
`endif
          end
        end
      end
`ifdef VSRC_GAP_EN
      GAP: begin
        if (gap_cnt_q == 16'd0) begin
          state_d = HEAD;
          valid_d = 1'b1;
          data_d  = fmt_flit;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
`endif
      DONE:    ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef VSRC_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef VSRC_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule
